// File: rtl/psi_pkg.sv
// Shared types and helpers for the PSI result streamer.
// Holds the FSM state type, the absent sentinel and width helpers.
package psi_pkg;

    typedef enum logic [1:0] {
        PSI_IDLE = 2'd0,
        PSI_SEND = 2'd1,
        PSI_DONE = 2'd2
    } psi_state_t;

    localparam int unsigned PSI_EMPTY = 0;

    function automatic int psi_cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

    function automatic int psi_idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/psi_lsb_enc.sv
// Lowest-set-bit encoder for the pending-element mask.
// Also flags when exactly one bit is left (the final element).
module psi_lsb_enc
    import psi_pkg::*;
#(
    parameter int K = 8,
    localparam int IW = psi_idx_w(K)
) (
    input  logic [K-1:0]  mask_i,
    output logic [IW-1:0] sel_o,
    output logic          one_hot_only_o
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        sel_o = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (mask_i[i]) sel_o = IW'(i);
        end
        one_hot_only_o = (mask_i != '0) &&
                         ((mask_i & (mask_i - K'(1))) == '0);
    end

endmodule

// File: rtl/psi_stream_out.sv
// Serialises a sparse PSI result array into a compact element stream.
// Non-zero elements leave in ascending index order, then done/count.
module psi_stream_out
    import psi_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 8,
    localparam int CW = psi_cnt_w(K),
    localparam int IW = psi_idx_w(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*K-1:0] in_array,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           done,
    output logic [CW-1:0]  count
);

    psi_state_t      state_q;
    logic [W-1:0]    data_q [K];
    logic [K-1:0]    mask_q;
    logic [CW-1:0]   count_q;
    logic [K-1:0]    nz_d;
    logic [IW-1:0]   sel;
    logic            one_left;

    psi_lsb_enc #(.K(K)) u_enc (
        .mask_i         (mask_q),
        .sel_o          (sel),
        .one_hot_only_o (one_left)
    );

    // Non-zero map of the incoming array.
    always_comb begin
        nz_d = '0;
        for (int i = 0; i < K; i++) begin
            nz_d[i] = in_array[i*W +: W] != W'(PSI_EMPTY);
        end
    end

    // Load, drain and finish FSM; reset always wins over a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PSI_IDLE;
            mask_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < K; i++) data_q[i] <= '0;
        end else begin
            unique case (state_q)
                PSI_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < K; i++) begin
                            data_q[i] <= in_array[i*W +: W];
                        end
                        mask_q  <= nz_d;
                        count_q <= '0;
                        state_q <= (nz_d == '0) ? PSI_DONE : PSI_SEND;
                    end
                end
                PSI_SEND: begin
                    if (out_ready) begin
                        mask_q[sel] <= 1'b0;
                        count_q     <= count_q + CW'(1);
                        if (one_left) state_q <= PSI_DONE;
                    end
                end
                PSI_DONE: begin
                    state_q <= PSI_IDLE;
                end
                default: begin
                    state_q <= PSI_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state; data/last are zero when idle.
    always_comb begin
        in_ready  = state_q == PSI_IDLE;
        out_valid = state_q == PSI_SEND;
        done      = state_q == PSI_DONE;
        out_data  = out_valid ? data_q[sel] : '0;
        out_last  = out_valid & one_left;
        count     = count_q;
    end

endmodule
